piccolo_param_core: RTL

Iterative Piccolo-80/128 encryption core with a run-time key port, per-transaction key-length select and a configurable unroll factor. It replaces the fixed-key, fixed-7-round-per-cycle datapath. Plaintext/key enter through a valid/ready handshake; ciphertext leaves through a valid/ready handshake with back-pressure. The core sits between the host-side stimulus FIFO and the ciphertext capture logic of the side-channel test harness.

---
 rtl/piccolo_param_core.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/piccolo_param_core.sv
// rtl/piccolo_param_core.sv - iterative Piccolo-80/128 encryption core, UNROLL rounds per clock
module piccolo_param_core #(
    parameter int UNROLL = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode128,
    input  logic [127:0] key,
    input  logic [63:0]  plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  ciphertext,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q;
    logic         in_ready_q, out_valid_q, busy_q, mode_q;
    logic [4:0]   r_q;
    logic [63:0]  state_q, ct_q, state_d;
    logic [127:0] keys_q, keys_d;
    logic [31:0]  wkout_q;
    logic [4:0]   rmax;
    logic         last_run;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'he;  4'h1: return 4'h4;  4'h2: return 4'hb;  4'h3: return 4'h2;
            4'h4: return 4'h3;  4'h5: return 4'h8;  4'h6: return 4'h0;  4'h7: return 4'h9;
            4'h8: return 4'h1;  4'h9: return 4'ha;  4'ha: return 4'h7;  4'hb: return 4'hf;
            4'hc: return 4'h6;  4'hd: return 4'hc;  4'he: return 4'h5;  default: return 4'hd;
        endcase
    endfunction

    // multiply by x in GF(2^4) modulo x^4+x+1
    function automatic logic [3:0] gm2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
    endfunction

    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [3:0] s0, s1, s2, s3, y0, y1, y2, y3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        y0 = gm2(s0) ^ gm2(s1) ^ s1 ^ s2 ^ s3;
        y1 = s0 ^ gm2(s1) ^ gm2(s2) ^ s2 ^ s3;
        y2 = s0 ^ s1 ^ gm2(s2) ^ gm2(s3) ^ s3;
        y3 = gm2(s0) ^ s0 ^ s1 ^ s2 ^ gm2(s3);
        return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
    endfunction

    function automatic logic [63:0] rp(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    function automatic logic [127:0] kperm(input logic [127:0] k);
        return {k[95:80], k[111:96], k[31:16], k[15:0], k[127:112], k[79:64], k[63:48], k[47:32]};
    endfunction

    function automatic logic [15:0] kword(input logic [127:0] k, input logic [2:0] n);
        case (n)
            3'd0: return k[127:112];  3'd1: return k[111:96];
            3'd2: return k[95:80];    3'd3: return k[79:64];
            3'd4: return k[63:48];    3'd5: return k[47:32];
            3'd6: return k[31:16];    default: return k[15:0];
        endcase
    endfunction

    function automatic logic [31:0] con(input logic [4:0] i, input logic m128);
        logic [4:0] c;
        c = i + 5'd1;
        return {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ (m128 ? 32'h6547a98b : 32'h0f1e2d3c);
    endfunction

    assign rmax     = mode_q ? 5'd31 : 5'd25;
    assign last_run = ({1'b0, r_q} + 6'(UNROLL)) >= {1'b0, rmax};

    logic [63:0]  st [0:UNROLL];
    logic [127:0] ks [0:UNROLL];
    logic [5:0]   idx, m80;
    logic [1:0]   sel;
    logic [63:0]  xs;
    logic [127:0] kcur;
    logic [15:0]  rka, rkb;
    logic [31:0]  cv;

    // Round slices; the 128-bit key state is permuted in place before every round i with i%4 == 3
    always_comb begin
        st[0] = state_q;
        ks[0] = keys_q;
        idx   = '0;
        m80   = '0;
        sel   = '0;
        xs    = '0;
        kcur  = '0;
        rka   = '0;
        rkb   = '0;
        cv    = '0;
        for (int j = 0; j < UNROLL; j++) begin
            idx  = {1'b0, r_q} + 6'(j);
            kcur = ks[j];
            xs   = st[j];
            if (idx < {1'b0, rmax}) begin
                if (mode_q) begin
                    if (idx[1:0] == 2'd3) kcur = kperm(kcur);
                    sel = idx[1:0] + 2'd1;
                    rka = kword(kcur, {sel, 1'b0});
                    rkb = kword(kcur, {sel, 1'b1});
                end else begin
                    m80 = idx % 6'd5;
                    case (m80)
                        6'd0, 6'd2: begin rka = kword(kcur, 3'd2); rkb = kword(kcur, 3'd3); end
                        6'd1, 6'd4: begin rka = kword(kcur, 3'd0); rkb = kword(kcur, 3'd1); end
                        default:    begin rka = kword(kcur, 3'd4); rkb = kword(kcur, 3'd4); end
                    endcase
                end
                cv = con(idx[4:0], mode_q);
                xs = {xs[63:48], xs[47:32] ^ f_fn(xs[63:48]) ^ rka ^ cv[31:16],
                      xs[31:16], xs[15:0]  ^ f_fn(xs[31:16]) ^ rkb ^ cv[15:0]};
                if (idx != ({1'b0, rmax} - 6'd1)) xs = rp(xs);
            end
            st[j+1] = xs;
            ks[j+1] = kcur;
        end
        state_d = st[UNROLL];
        keys_d  = ks[UNROLL];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ct_q        <= '0;
            r_q         <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        fsm_q      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        r_q        <= '0;
                        mode_q     <= mode128;
                        keys_q     <= key;
                        state_q    <= {plaintext[63:48] ^ {key[127:120], key[103:96]},
                                       plaintext[47:32],
                                       plaintext[31:16] ^ {key[111:104], key[119:112]},
                                       plaintext[15:0]};
                        wkout_q    <= mode128 ? {key[63:56], key[7:0], key[15:8], key[55:48]}
                                              : {key[63:56], key[71:64], key[79:72], key[55:48]};
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    keys_q  <= keys_d;
                    if (last_run) begin
                        fsm_q       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        r_q         <= rmax;
                        ct_q        <= {state_d[63:48] ^ wkout_q[31:16], state_d[47:32],
                                        state_d[31:16] ^ wkout_q[15:0],  state_d[15:0]};
                    end else begin
                        r_q <= r_q + 5'(UNROLL);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = ct_q;

endmodule
